ir_command_transmitter: RTL and testbench
=========================================

// Module: ir_command_transmitter
// PURPOSE
// - Serialises the 12-bit move command from the main FSM into Sony-SIRC-style IR frames on a 40 kHz carrier.
// - Sits directly downstream of the main FSM: consumes move_command and the transmit_ir level, and drives the IR LED pin.
// - Repeats whole frames for as long as transmit is held, so a dropped frame on the rover side is recovered by the next one.
// PARAMETERS
// - UNIT_CYCLES   16200    cycles per 600 us timing unit at 27 MHz
// - CARRIER_HALF  338      cycles per carrier half-period (~40 kHz)
// - FRAME_CYCLES  1215000  cycles from one start-mark onset to the next (45 ms)
// PORTS
// - clock        in   1   system clock, 27 MHz
// - reset        in   1   synchronous, active-high
// - transmit     in   1   level; frames repeat while high
// - command      in   12  [7:0] distance, [11:8] angle; sampled at frame start
// - ir_out       out  1   modulated IR LED drive
// - busy         out  1   high from frame start until the frame slot ends
// - frame_done   out  1   one-cycle pulse at the end of the last bit mark
// BEHAVIOUR
// - Single clock domain; reset is synchronous, active-high.
// - Reset values: ir_out=0, busy=0, frame_done=0, state=IDLE, all counters=0, latched command=0.
// - Reset asserted mid-frame aborts on the next edge and drives ir_out low; no partial-frame completion.
// - Frame format: start mark of 4U, then per bit (LSB first): space 1U, then mark 2U for '1' or 1U for '0'. U=UNIT_CYCLES.
// - Mark: ir_out = carrier. Space and gap: ir_out = 0.
// - Carrier: toggle every CARRIER_HALF cycles. The phase restarts at every mark onset, so the first half-period is high.
// - States:
//   - IDLE -> START when transmit=1. On that edge: latch command, set busy=1, clear the frame counter.
//   - START (4U) -> SPACE.
//   - SPACE (1U) -> MARK.
//   - MARK (1U/2U) -> SPACE if bits remain; otherwise pulse frame_done and go to GAP.
//   - GAP -> waits until the frame counter reaches FRAME_CYCLES-1.
//     - If transmit=1: go to START, relatch command, clear the frame counter.
//     - If transmit=0: go to IDLE with busy=0.
// - Latency: the first carrier-high cycle on ir_out is the cycle after transmit is first sampled high in IDLE.
// - transmit dropping mid-frame does not truncate: the current frame and its gap finish, then the block idles.
// - command changes mid-frame are ignored until the next frame's latch.
// - The frame counter is 21 bits and saturates at FRAME_CYCLES-1; it never wraps.
// - Bit counter: 4 bits, counts 0..NBITS-1. NBITS=12, or 13 with parity.
// - Max frame = 4+NBITS*3 U, which is below FRAME_CYCLES at defaults, so the gap is always >=0.
// - If transmit goes high in the same cycle GAP ends, it is treated as a repeat (START), with no IDLE cycle.
// CONFIGURATION
// - IR_PARITY_EN defined:
//   - A 13th bit is appended after bit 11, equal to the even parity (XOR) of the 12 latched bits.
//   - It uses the same space/mark encoding; frame_done pulses after the parity mark.
// - IR_PARITY_EN undefined: exactly 12 bits per frame; no parity logic is synthesised.
// TESTING
// - Bench parameters: UNIT_CYCLES=10, CARRIER_HALF=2, FRAME_CYCLES=600.
// - reset held 3 cycles, transmit=0 -> ir_out=0, busy=0, frame_done=0 for 100 cycles.
// - command=12'h00A, transmit pulsed high 1 cycle:
//   - busy rises on the next edge.
//   - Decoded mark lengths are 40, then 10,20,10,20,10x8 (LSB first).
//   - frame_done pulses once; busy falls at cycle 600; no second frame.
// - command=12'hFFF, transmit held high 1500 cycles:
//   - Frame onsets occur at 0, 600 and 1200, each frame holding 12 marks of 20.
//   - After the transmit drop, the third frame completes and busy falls at 1800.
// - command changed 12'h00A->12'h3C5 mid-frame with transmit held:
//   - The current frame still encodes 00A.
//   - The next frame encodes 3C5.
// - Reset asserted during the bit-5 mark -> ir_out=0 and busy=0 on the next edge; IDLE resumes with no frame_done.
// - With IR_PARITY_EN and command=12'h007:
//   - 13 marks, with the last mark 20 cycles (parity=1).
//   - With command=12'h003 the last mark is 10 cycles.

Source files
------------

// File: rtl/ir_command_transmitter.sv
// ir_command_transmitter: serialises a 12-bit move command into SIRC-style IR frames on a modulated carrier.
// Build option: define IR_PARITY_EN to append an even-parity 13th bit to every frame.
module ir_command_transmitter #(
  parameter int unsigned UNIT_CYCLES  = 16200,
  parameter int unsigned CARRIER_HALF = 338,
  parameter int unsigned FRAME_CYCLES = 1215000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        transmit,
  input  logic [11:0] command,
  output logic        ir_out,
  output logic        busy,
  output logic        frame_done,
  output logic [2:0]  state_o
);

  localparam int unsigned SEG_W = $clog2(4 * UNIT_CYCLES);
  localparam int unsigned CAR_W = $clog2(CARRIER_HALF) + 1;
  localparam logic [SEG_W-1:0] START_LAST = SEG_W'(4 * UNIT_CYCLES - 1);
  localparam logic [SEG_W-1:0] ONE_U_LAST = SEG_W'(UNIT_CYCLES - 1);
  localparam logic [SEG_W-1:0] TWO_U_LAST = SEG_W'(2 * UNIT_CYCLES - 1);
  localparam logic [CAR_W-1:0] CAR_LAST   = CAR_W'(CARRIER_HALF - 1);
  localparam logic [20:0]      FRAME_LAST = 21'(FRAME_CYCLES - 1);
`ifdef IR_PARITY_EN
  localparam logic [3:0] LAST_BIT = 4'd12;
`else
  localparam logic [3:0] LAST_BIT = 4'd11;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_SPACE = 3'd2,
    S_MARK  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [SEG_W-1:0] seg_q, seg_d, seg_last;
  logic [CAR_W-1:0] car_q, car_d;
  logic             carrier_q, carrier_d;
  logic [20:0]      frame_q, frame_d;
  logic [3:0]       bit_q, bit_d;
  logic [11:0]      cmd_q, cmd_d;
  logic [15:0]      bits_ext;
  logic             cur_bit, seg_done, last_bit, frame_end;
  logic             start_frame, mark_onset;

  // Bit 12 (when present) is the even parity of the latched command.
`ifdef IR_PARITY_EN
  assign bits_ext = {3'b000, ^cmd_q, cmd_q};
`else
  assign bits_ext = {4'b0000, cmd_q};
`endif

  assign cur_bit   = bits_ext[bit_q];
  assign last_bit  = (bit_q == LAST_BIT);
  assign frame_end = (frame_q == FRAME_LAST);

  always_comb begin
    seg_last = ONE_U_LAST;
    case (state_q)
      S_START: seg_last = START_LAST;
      S_MARK:  seg_last = cur_bit ? TWO_U_LAST : ONE_U_LAST;
      default: seg_last = ONE_U_LAST;
    endcase
  end

  assign seg_done = (seg_q == seg_last);

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // transmit is a plain level: sampled in IDLE and again only when the frame slot ends.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (transmit) state_d = S_START;
      S_START: if (seg_done) state_d = S_SPACE;
      S_SPACE: if (seg_done) state_d = S_MARK;
      S_MARK:  if (seg_done) state_d = last_bit ? S_GAP : S_SPACE;
      S_GAP:   if (frame_end) state_d = transmit ? S_START : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    ir_out     = ((state_q == S_START) || (state_q == S_MARK)) && carrier_q;
    frame_done = (state_q == S_MARK) && seg_done && last_bit;
    state_o    = state_q;
  end

  always_comb begin
    start_frame = (state_d == S_START) && (state_q != S_START);
    mark_onset  = start_frame || ((state_q == S_SPACE) && (state_d == S_MARK));

    if ((state_d != state_q) || (state_q == S_IDLE) || (state_q == S_GAP)) seg_d = '0;
    else                                                                  seg_d = seg_q + 1'b1;

    // Carrier phase restarts high at each mark onset.
    if (mark_onset) begin
      car_d     = '0;
      carrier_d = 1'b1;
    end else if ((state_q == S_START) || (state_q == S_MARK)) begin
      if (car_q == CAR_LAST) begin
        car_d     = '0;
        carrier_d = ~carrier_q;
      end else begin
        car_d     = car_q + 1'b1;
        carrier_d = carrier_q;
      end
    end else begin
      car_d     = '0;
      carrier_d = 1'b0;
    end

    if (start_frame || (state_q == S_IDLE)) frame_d = '0;
    else if (!frame_end)                   frame_d = frame_q + 21'd1;
    else                                   frame_d = frame_q;

    if (start_frame)                                      bit_d = 4'd0;
    else if ((state_q == S_MARK) && seg_done && !last_bit) bit_d = bit_q + 4'd1;
    else                                                  bit_d = bit_q;

    cmd_d = start_frame ? command : cmd_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      seg_q     <= '0;
      car_q     <= '0;
      carrier_q <= 1'b0;
      frame_q   <= '0;
      bit_q     <= 4'd0;
      cmd_q     <= 12'd0;
    end else begin
      seg_q     <= seg_d;
      car_q     <= car_d;
      carrier_q <= carrier_d;
      frame_q   <= frame_d;
      bit_q     <= bit_d;
      cmd_q     <= cmd_d;
    end
  end

endmodule

// File: tb/tb_ir_command_transmitter.sv
// Bench for ir_command_transmitter: per-cycle stimulus tables checked against a frame-level waveform model.
// Honours IR_PARITY_EN the same way the design does.
module tb_ir_command_transmitter;

  localparam int U    = 10;
  localparam int CH   = 2;
  localparam int FR   = 600;
  localparam int MAXW = 2000;
`ifdef IR_PARITY_EN
  localparam int NB = 13;
`else
  localparam int NB = 12;
`endif

  logic        clock = 1'b0;
  logic        reset, transmit;
  logic [11:0] command;
  logic        ir_out, busy, frame_done;
  logic [2:0]  dbg_state;

  always #5 clock = ~clock;

  ir_command_transmitter #(
    .UNIT_CYCLES(U), .CARRIER_HALF(CH), .FRAME_CYCLES(FR)
  ) dut (
    .clock(clock), .reset(reset), .transmit(transmit), .command(command),
    .ir_out(ir_out), .busy(busy), .frame_done(frame_done), .state_o(dbg_state)
  );

  logic        tx_a[MAXW], rst_a[MAXW];
  logic [11:0] cmd_a[MAXW];
  logic        ir_a[MAXW], busy_a[MAXW], fd_a[MAXW];
  logic        exp_ir[MAXW], exp_busy[MAXW], exp_fd[MAXW];
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];

  int checks = 0;
  int errors = 0;
  int ir_bad, ir_first, bsy_bad, bsy_first, fd_bad, fd_first, on_bad, fd_cnt;

  // ---------------- reference model: frame built from the encoding rules ----------------
  function automatic logic bit_of(input logic [11:0] c, input int i);
    if (i < 12) return c[i];
    return ^c;
  endfunction

  // Segment 0 is the start mark; odd segments are spaces; even segments >0 are bit marks.
  function automatic int seg_len(input logic [11:0] c, input int s);
    if (s == 0) return 4 * U;
    if (s % 2 == 1) return U;
    return bit_of(c, (s - 2) / 2) ? 2 * U : U;
  endfunction

  function automatic int frame_len(input logic [11:0] c);
    int t = 0;
    for (int s = 0; s <= 2 * NB; s++) t += seg_len(c, s);
    return t;
  endfunction

  function automatic logic ir_model(input logic [11:0] c, input int j);
    int pos = 0;
    for (int s = 0; s <= 2 * NB; s++) begin
      int len = seg_len(c, s);
      if (j < pos + len) return (s % 2 == 0) ? (((j - pos) / CH) % 2 == 0) : 1'b0;
      pos += len;
    end
    return 1'b0;
  endfunction

  task automatic model_window(input int n);
    bit          active = 0;
    int          onset  = 0;
    logic [11:0] lc     = '0;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      if (rst_a[k]) active = 0;
      else if (!active) begin
        if (tx_a[k]) begin active = 1; onset = k; lc = cmd_a[k]; exp_q.push_back(16'(k)); end
      end else if (k - onset == FR) begin
        if (tx_a[k]) begin onset = k; lc = cmd_a[k]; exp_q.push_back(16'(k)); end
        else active = 0;
      end
      exp_busy[k] = active;
      exp_ir[k]   = active ? ir_model(lc, k - onset) : 1'b0;
      exp_fd[k]   = active && (k - onset == frame_len(lc) - 1);
    end
  endtask

  // ---------------- driver ----------------
  task automatic clear_stim();
    for (int k = 0; k < MAXW; k++) begin tx_a[k] = 0; rst_a[k] = 0; cmd_a[k] = '0; end
  endtask

  task automatic run_window(input int n);
    for (int k = 0; k < n; k++) begin
      reset = rst_a[k]; transmit = tx_a[k]; command = cmd_a[k];
      @(posedge clock); #1;
      ir_a[k] = ir_out; busy_a[k] = busy; fd_a[k] = frame_done;
    end
    reset = 1'b0; transmit = 1'b0;
  endtask

  // Tallies differences against the model; each test judges the tallies itself.
  task automatic score_window(input int n);
    int low_run = 50;
    model_window(n);
    ir_bad = 0; bsy_bad = 0; fd_bad = 0; ir_first = 0; bsy_first = 0; fd_first = 0; fd_cnt = 0;
    obs_q.delete();
    for (int k = 0; k < n; k++) begin
      if (ir_a[k] !== exp_ir[k])     begin if (ir_bad == 0) ir_first = k;   ir_bad++;  end
      if (busy_a[k] !== exp_busy[k]) begin if (bsy_bad == 0) bsy_first = k; bsy_bad++; end
      if (fd_a[k] !== exp_fd[k])     begin if (fd_bad == 0) fd_first = k;   fd_bad++;  end
      if (fd_a[k] === 1'b1) fd_cnt++;
      if (ir_a[k] === 1'b1) begin
        if (low_run >= 50) obs_q.push_back(16'(k));
        low_run = 0;
      end else low_run++;
    end
    on_bad = (obs_q.size() != exp_q.size());
    if (!on_bad) foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) on_bad = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; transmit = 1'b0; command = 12'h000;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (ir_out !== 1'b0) begin errors++; $display("FAIL reset ir_out: got %b want 0", ir_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset frame_done: got %b want 0", frame_done); end
    reset = 1'b0;
    clear_stim();
    run_window(100);
    score_window(100);
    checks++; if (ir_bad != 0) begin errors++; $display("FAIL idle ir_out: %0d bad, first k=%0d got %b want %b", ir_bad, ir_first, ir_a[ir_first], exp_ir[ir_first]); end
    checks++; if (bsy_bad != 0) begin errors++; $display("FAIL idle busy: %0d bad, first k=%0d got %b want %b", bsy_bad, bsy_first, busy_a[bsy_first], exp_busy[bsy_first]); end
    checks++; if (fd_cnt != 0) begin errors++; $display("FAIL idle frame_done: got %0d pulses want 0", fd_cnt); end
  endtask

  task automatic test_single_frame();
    clear_stim();
    for (int k = 0; k < 800; k++) cmd_a[k] = 12'h00A;
    tx_a[0] = 1'b1;
    run_window(800);
    score_window(800);
    checks++; if (ir_bad != 0) begin errors++; $display("FAIL single ir_wave: %0d bad, first k=%0d got %b want %b", ir_bad, ir_first, ir_a[ir_first], exp_ir[ir_first]); end
    checks++; if (bsy_bad != 0) begin errors++; $display("FAIL single busy: %0d bad, first k=%0d got %b want %b", bsy_bad, bsy_first, busy_a[bsy_first], exp_busy[bsy_first]); end
    checks++; if (fd_bad != 0) begin errors++; $display("FAIL single frame_done: %0d bad, first k=%0d got %b want %b", fd_bad, fd_first, fd_a[fd_first], exp_fd[fd_first]); end
    checks++; if (on_bad != 0) begin errors++; $display("FAIL single onsets: got %0d frames want %0d", obs_q.size(), exp_q.size()); end
    checks++; if (busy_a[0] !== 1'b1 || ir_a[0] !== 1'b1) begin errors++; $display("FAIL single latency: busy=%b ir=%b at k=0 want 1 1", busy_a[0], ir_a[0]); end
    checks++; if (busy_a[599] !== 1'b1 || busy_a[600] !== 1'b0) begin errors++; $display("FAIL single busy_fall: k599=%b k600=%b want 1 0", busy_a[599], busy_a[600]); end
    checks++; if (fd_cnt != 1) begin errors++; $display("FAIL single fd_count: got %0d want 1", fd_cnt); end
`ifndef IR_PARITY_EN
    // 40 + (20+30+20+30) + 8*20 = 300 cycles of marks and spaces.
    checks++; if (fd_a[299] !== 1'b1) begin errors++; $display("FAIL single fd_pos: k299=%b want 1", fd_a[299]); end
`endif
  endtask

  task automatic test_repeat();
    clear_stim();
    for (int k = 0; k < 2000; k++) begin cmd_a[k] = 12'hFFF; tx_a[k] = (k < 1500); end
    run_window(2000);
    score_window(2000);
    checks++; if (ir_bad != 0) begin errors++; $display("FAIL repeat ir_wave: %0d bad, first k=%0d got %b want %b", ir_bad, ir_first, ir_a[ir_first], exp_ir[ir_first]); end
    checks++; if (bsy_bad != 0) begin errors++; $display("FAIL repeat busy: %0d bad, first k=%0d got %b want %b", bsy_bad, bsy_first, busy_a[bsy_first], exp_busy[bsy_first]); end
    checks++; if (fd_bad != 0) begin errors++; $display("FAIL repeat frame_done: %0d bad, first k=%0d got %b want %b", fd_bad, fd_first, fd_a[fd_first], exp_fd[fd_first]); end
    checks++; if (obs_q.size() != 3 || obs_q[0] != 0 || obs_q[1] != 600 || obs_q[2] != 1200) begin
      errors++; $display("FAIL repeat onsets: got %0d frames want 3 at 0/600/1200", obs_q.size()); end
    checks++; if (busy_a[1799] !== 1'b1 || busy_a[1800] !== 1'b0) begin errors++; $display("FAIL repeat busy_fall: k1799=%b k1800=%b want 1 0", busy_a[1799], busy_a[1800]); end
    checks++; if (fd_cnt != 3) begin errors++; $display("FAIL repeat fd_count: got %0d want 3", fd_cnt); end
  endtask

  task automatic test_cmd_change();
    clear_stim();
    for (int k = 0; k < 1600; k++) begin cmd_a[k] = (k < 300) ? 12'h00A : 12'h3C5; tx_a[k] = (k < 900); end
    run_window(1600);
    score_window(1600);
    checks++; if (ir_bad != 0) begin errors++; $display("FAIL cmdchg ir_wave: %0d bad, first k=%0d got %b want %b", ir_bad, ir_first, ir_a[ir_first], exp_ir[ir_first]); end
    checks++; if (bsy_bad != 0) begin errors++; $display("FAIL cmdchg busy: %0d bad, first k=%0d got %b want %b", bsy_bad, bsy_first, busy_a[bsy_first], exp_busy[bsy_first]); end
    checks++; if (fd_bad != 0) begin errors++; $display("FAIL cmdchg frame_done: %0d bad, first k=%0d got %b want %b", fd_bad, fd_first, fd_a[fd_first], exp_fd[fd_first]); end
    checks++; if (on_bad != 0) begin errors++; $display("FAIL cmdchg onsets: got %0d frames want %0d", obs_q.size(), exp_q.size()); end
`ifndef IR_PARITY_EN
    // First frame still 00A (ends at 299); second is 3C5: six ones, six zeros -> 340 cycles.
    checks++; if (fd_a[299] !== 1'b1 || fd_a[939] !== 1'b1) begin errors++; $display("FAIL cmdchg fd_pos: k299=%b k939=%b want 1 1", fd_a[299], fd_a[939]); end
`endif
  endtask

  task automatic test_reset_mid_frame();
    clear_stim();
    for (int k = 0; k < 1000; k++) cmd_a[k] = 12'h00A;
    tx_a[0]    = 1'b1;
    // Bit-5 mark of 00A spans k=170..179; reset lands inside it.
    rst_a[173] = 1'b1;
    tx_a[300]  = 1'b1;
    run_window(1000);
    score_window(1000);
    checks++; if (ir_bad != 0) begin errors++; $display("FAIL rstmid ir_wave: %0d bad, first k=%0d got %b want %b", ir_bad, ir_first, ir_a[ir_first], exp_ir[ir_first]); end
    checks++; if (bsy_bad != 0) begin errors++; $display("FAIL rstmid busy: %0d bad, first k=%0d got %b want %b", bsy_bad, bsy_first, busy_a[bsy_first], exp_busy[bsy_first]); end
    checks++; if (ir_a[170] !== 1'b1 || ir_a[173] !== 1'b0 || busy_a[173] !== 1'b0) begin
      errors++; $display("FAIL rstmid abort: ir170=%b ir173=%b busy173=%b want 1 0 0", ir_a[170], ir_a[173], busy_a[173]); end
    checks++; if (fd_a[299] !== 1'b0 || fd_cnt != 1) begin errors++; $display("FAIL rstmid fd: k299=%b count=%0d want 0 and 1", fd_a[299], fd_cnt); end
    checks++; if (on_bad != 0) begin errors++; $display("FAIL rstmid onsets: got %0d frames want %0d", obs_q.size(), exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] c;
    clear_stim();
    c = 12'($urandom);
    for (int k = 0; k < 1300; k++) begin cmd_a[k] = c; tx_a[k] = (k == 0) || (k >= 590 && k <= 600); end
    run_window(1300);
    score_window(1300);
    checks++; if (ir_bad != 0) begin errors++; $display("FAIL b2b ir_wave cmd=%h: %0d bad, first k=%0d got %b want %b", c, ir_bad, ir_first, ir_a[ir_first], exp_ir[ir_first]); end
    checks++; if (fd_bad != 0) begin errors++; $display("FAIL b2b frame_done: %0d bad, first k=%0d got %b want %b", fd_bad, fd_first, fd_a[fd_first], exp_fd[fd_first]); end
    checks++; if (busy_a[599] !== 1'b1 || busy_a[600] !== 1'b1 || busy_a[1200] !== 1'b0) begin
      errors++; $display("FAIL b2b busy: k599=%b k600=%b k1200=%b want 1 1 0", busy_a[599], busy_a[600], busy_a[1200]); end
    checks++; if (obs_q.size() != 2 || obs_q[1] != 600) begin errors++; $display("FAIL b2b onsets: got %0d frames want 2 at 0/600", obs_q.size()); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      logic [11:0] c;
      logic        tx;
      int          run;
      clear_stim();
      c = 12'($urandom); tx = 1'b1; run = $urandom_range(1, 300);
      for (int k = 0; k < 1500; k++) begin
        if (run == 0) begin tx = 1'($urandom_range(0, 1)); run = $urandom_range(1, 300); end
        run--;
        if ($urandom_range(0, 149) == 0) c = 12'($urandom);
        cmd_a[k] = c;
        tx_a[k]  = (k < 800) ? tx : 1'b0;
      end
      run_window(1500);
      score_window(1500);
      checks++; if (ir_bad != 0) begin errors++; $display("FAIL rand%0d ir_wave: %0d bad, first k=%0d got %b want %b", it, ir_bad, ir_first, ir_a[ir_first], exp_ir[ir_first]); end
      checks++; if (bsy_bad != 0) begin errors++; $display("FAIL rand%0d busy: %0d bad, first k=%0d got %b want %b", it, bsy_bad, bsy_first, busy_a[bsy_first], exp_busy[bsy_first]); end
      checks++; if (fd_bad != 0) begin errors++; $display("FAIL rand%0d frame_done: %0d bad, first k=%0d got %b want %b", it, fd_bad, fd_first, fd_a[fd_first], exp_fd[fd_first]); end
      checks++; if (on_bad != 0) begin errors++; $display("FAIL rand%0d onsets: got %0d frames want %0d", it, obs_q.size(), exp_q.size()); end
    end
  endtask

`ifdef IR_PARITY_EN
  task automatic test_parity();
    logic [11:0] cmds[2] = '{12'h007, 12'h003};
    int          ends[2] = '{339, 319};
    for (int t = 0; t < 2; t++) begin
      clear_stim();
      for (int k = 0; k < 700; k++) cmd_a[k] = cmds[t];
      tx_a[0] = 1'b1;
      run_window(700);
      score_window(700);
      checks++; if (ir_bad != 0) begin errors++; $display("FAIL parity %h ir_wave: %0d bad, first k=%0d got %b want %b", cmds[t], ir_bad, ir_first, ir_a[ir_first], exp_ir[ir_first]); end
      checks++; if (fd_a[ends[t]] !== 1'b1 || fd_cnt != 1) begin
        errors++; $display("FAIL parity %h fd_pos: k%0d=%b count=%0d want 1 and 1", cmds[t], ends[t], fd_a[ends[t]], fd_cnt); end
    end
  endtask
`endif

  initial begin
    reset = 1'b1; transmit = 1'b0; command = 12'h000;
    test_reset();
    test_single_frame();
    test_repeat();
    test_cmd_change();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
`ifdef IR_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
